// File: rtl/order_packer_if.sv
// Order-in / packed-word-out handshake bundle for order_packer.
// The slave modport is the packer; the master modport is the side that feeds it and drains words.
interface order_packer_if;
  logic        ord_valid;
  logic [2:0]  ord_code;
  logic        ord_ready;
  logic        flush;
  logic        word_valid;
  logic [23:0] word_data;
  logic        word_ready;
  logic [7:0]  word_count;

  modport master (
    output ord_valid, ord_code, flush, word_ready,
    input  ord_ready, word_valid, word_data, word_count
  );

  modport slave (
    input  ord_valid, ord_code, flush, word_ready,
    output ord_ready, word_valid, word_data, word_count
  );
endinterface

// File: rtl/order_packer.sv
// Packs up to MAX_ORDERS 3-bit order codes into a 24-bit word {count, slot7..slot1}.
// The word is emitted when full or on flush, and held until the downstream accepts it.
module order_packer #(
  parameter int MAX_ORDERS = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  order_packer_if.slave bus
);

  typedef enum logic {FILL, EMIT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  count_q, count_d;
  logic [20:0] slots_q, slots_d;
  logic [7:0]  word_count_q, word_count_d;
  logic        accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      count_q      <= 3'd0;
      slots_q      <= 21'd0;
      word_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      slots_q      <= slots_d;
      word_count_q <= word_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    slots_d      = slots_q;
    word_count_d = word_count_q;
    accept       = 1'b0;

    case (state_q)
      FILL: begin
        accept = bus.ord_valid;
        if (accept) begin
          count_d = count_q + 3'd1;
          for (int k = 0; k < 7; k++) begin
            if (count_q == 3'(k)) begin
              slots_d[3*k +: 3] = bus.ord_code;
            end
          end
        end
        // An order arriving with flush is counted first, so it rides in the emitted word.
        if ((accept && count_d == 3'(MAX_ORDERS)) || (bus.flush && count_d != 3'd0)) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (bus.word_ready) begin
          state_d      = FILL;
          count_d      = 3'd0;
          slots_d      = 21'd0;
          word_count_d = word_count_q + 8'd1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign bus.ord_ready  = (state_q == FILL);
  assign bus.word_valid = (state_q == EMIT);
  assign bus.word_data  = {count_q, slots_q};
  assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_order_packer.sv
// Directed self-checking bench for order_packer with hand-computed packed words.
module tb_order_packer;

  logic clk;
  logic rst_n;
  int   testCount;
  int   failCount;

  order_packer_if bus();

  order_packer #(.MAX_ORDERS(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then land 1ns after the edge for checking.
  task automatic applyStimulus(input logic valid, input logic [2:0] code, input logic flsh, input logic wready);
    bus.ord_valid  = valid;
    bus.ord_code   = code;
    bus.flush      = flsh;
    bus.word_ready = wready;
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag, input logic [7:0] wc);
    checkOutput({tag, "_ord_ready"}, 32'(bus.ord_ready), 32'd1);
    checkOutput({tag, "_word_valid"}, 32'(bus.word_valid), 32'd0);
    checkOutput({tag, "_word_data"}, 32'(bus.word_data), 32'h000000);
    checkOutput({tag, "_word_count"}, 32'(bus.word_count), 32'(wc));
  endtask

  initial begin
    testCount      = 0;
    failCount      = 0;
    rst_n          = 1'b0;
    bus.ord_valid  = 1'b0;
    bus.ord_code   = 3'd0;
    bus.flush      = 1'b0;
    bus.word_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkIdle("reset", 8'd0);
    rst_n = 1'b1;

    // Full word of codes 1..7, drained immediately.
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(1'b1, 3'(i), 1'b0, 1'b1);
      if (i == 2) checkOutput("partial_view", 32'(bus.word_data), 32'h400011);
    end
    checkOutput("full_valid", 32'(bus.word_valid), 32'd1);
    checkOutput("full_ord_ready", 32'(bus.ord_ready), 32'd0);
    checkOutput("full_data", 32'(bus.word_data), 32'hFF58D1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    checkIdle("full_done", 8'd1);

    // Partial flush after two orders.
    applyStimulus(1'b1, 3'd5, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'd3, 1'b0, 1'b1);
    checkOutput("pre_flush_valid", 32'(bus.word_valid), 32'd0);
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b1);
    checkOutput("flush_valid", 32'(bus.word_valid), 32'd1);
    checkOutput("flush_data", 32'(bus.word_data), 32'h40001D);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    checkIdle("flush_done", 8'd2);

    // Order and flush together on an empty packer, then a flush with nothing to send.
    applyStimulus(1'b1, 3'd6, 1'b1, 1'b1);
    checkOutput("simul_valid", 32'(bus.word_valid), 32'd1);
    checkOutput("simul_data", 32'(bus.word_data), 32'h200006);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    checkIdle("simul_done", 8'd3);
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b1);
    checkIdle("empty_flush", 8'd3);

    // Backpressure on a full word of all-3 codes while an order 4 is offered.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 3'd3, 1'b0, 1'b0);
    checkOutput("bp_data0", 32'(bus.word_data), 32'hEDB6DB);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 3'd4, (i == 2), 1'b0);
      checkOutput("bp_valid", 32'(bus.word_valid), 32'd1);
      checkOutput("bp_ord_ready", 32'(bus.ord_ready), 32'd0);
      checkOutput("bp_data", 32'(bus.word_data), 32'hEDB6DB);
    end
    applyStimulus(1'b1, 3'd4, 1'b0, 1'b1);
    checkOutput("bp_handshake_valid", 32'(bus.word_valid), 32'd0);
    checkOutput("bp_handshake_data", 32'(bus.word_data), 32'h000000);
    checkOutput("bp_handshake_count", 32'(bus.word_count), 32'd4);
    applyStimulus(1'b1, 3'd4, 1'b0, 1'b1);
    checkOutput("bp_held_order", 32'(bus.word_data), 32'h200004);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    checkOutput("no_stale_flush", 32'(bus.word_valid), 32'd0);
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
    checkOutput("bp_tail_data", 32'(bus.word_data), 32'h200004);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("fill_ignores_ready_valid", 32'(bus.word_valid), 32'd1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    checkIdle("bp_done", 8'd5);

    // Reset part way through a word.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'd1, 1'b0, 1'b1);
    bus.ord_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkIdle("mid_reset", 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) applyStimulus(1'b1, 3'(i), 1'b0, 1'b1);
    checkOutput("post_reset_valid", 32'(bus.word_valid), 32'd1);
    checkOutput("post_reset_data", 32'(bus.word_data), 32'hFF58D1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    checkIdle("post_reset_done", 8'd1);

    // Count wrap over 256 flushed words, starting from a clean reset.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      applyStimulus(1'b1, 3'd2, 1'b1, 1'b1);
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
      if (i == 255) checkOutput("wrap_255", 32'(bus.word_count), 32'd255);
    end
    checkOutput("wrap_0", 32'(bus.word_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
